// File: rtl/fsm_trace_checker_if.sv
// Sample/status bundle between the traced FSM environment and fsm_trace_checker.
// hist is present only when FSM_TRACE_CHK_HIST_EN is defined.
interface fsm_trace_checker_if #(
    parameter int CNT_W = 8
) ();
    logic             en;
    logic             clr;
    logic             a;
    logic [2:0]       sd;
    logic             err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] loop_cnt;
    logic [2:0]       first_exp;
    logic [2:0]       first_got;
    logic             busy;
`ifdef FSM_TRACE_CHK_HIST_EN
    logic [11:0]      hist;
`endif

    modport master (
        output en, clr, a, sd,
        input  err, err_sticky, err_cnt, loop_cnt, first_exp, first_got, busy
`ifdef FSM_TRACE_CHK_HIST_EN
        , input hist
`endif
    );

    modport slave (
        input  en, clr, a, sd,
        output err, err_sticky, err_cnt, loop_cnt, first_exp, first_got, busy
`ifdef FSM_TRACE_CHK_HIST_EN
        , output hist
`endif
    );
endinterface

// File: rtl/fsm_trace_checker.sv
// Purpose: predicts each sampled FSM state from the legal transition table and records mismatches.
// Latency: sample at edge k, status registered at edge k; no backpressure (en qualifies samples).
// FSM_TRACE_CHK_HIST_EN adds a 4-deep sampled-state history that freezes at the first error.
module fsm_trace_checker #(
    parameter int CNT_W       = 8,
    parameter bit HALT_ON_ERR = 1'b0
) (
    input logic                clk,
    input logic                reset,
    fsm_trace_checker_if.slave bus
);
    typedef enum logic [1:0] {INIT, TRACK, RESYNC, HALT} phase_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [2:0] nxt(input logic [2:0] s, input logic a_i);
        logic [2:0] n;
        n = s;
        case (s)
            3'd2:    n = 3'd6;
            3'd4:    n = a_i ? 3'd6 : 3'd2;
            3'd5:    n = 3'd4;
            3'd6:    n = a_i ? 3'd7 : 3'd5;
            3'd7:    n = 3'd5;
            default: n = s;
        endcase
        return n;
    endfunction

    phase_t           phase;
    logic [2:0]       prev_sd;
    logic             prev_a;
    logic             err_q;
    logic             sticky_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] loop_cnt_q;
    logic [2:0]       first_exp_q;
    logic [2:0]       first_got_q;
    logic             busy_q;
`ifdef FSM_TRACE_CHK_HIST_EN
    logic [11:0]      hist_q;
`endif

    logic [2:0] expected;
    logic       mismatch;
    logic       is_loop;

    // Only INIT and TRACK carry continuity, so only they are checked.
    always_comb begin
        expected = (phase == INIT) ? 3'd2 : nxt(prev_sd, prev_a);
        mismatch = bus.en && !bus.clr && (phase == INIT || phase == TRACK) &&
                   (bus.sd != expected);
        is_loop  = (phase == TRACK) && (prev_sd == 3'd7) && (bus.sd == 3'd5) && !mismatch;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase       <= INIT;
            prev_sd     <= 3'd0;
            prev_a      <= 1'b0;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
            err_cnt_q   <= '0;
            loop_cnt_q  <= '0;
            first_exp_q <= 3'd0;
            first_got_q <= 3'd0;
            busy_q      <= 1'b0;
`ifdef FSM_TRACE_CHK_HIST_EN
            hist_q      <= 12'd0;
`endif
        end else if (bus.clr) begin
            phase       <= RESYNC;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
            err_cnt_q   <= '0;
            loop_cnt_q  <= '0;
            first_exp_q <= 3'd0;
            first_got_q <= 3'd0;
            busy_q      <= 1'b0;
`ifdef FSM_TRACE_CHK_HIST_EN
            hist_q      <= 12'd0;
`endif
            if (bus.en) begin
                prev_sd <= bus.sd;
                prev_a  <= bus.a;
            end
        end else if (!bus.en) begin
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            if (phase == TRACK) phase <= RESYNC;
        end else if (phase == HALT) begin
            err_q <= 1'b0;
        end else begin
            // The observed state is adopted even on error so checking resynchronises.
            prev_sd <= bus.sd;
            prev_a  <= bus.a;
            err_q   <= mismatch;
`ifdef FSM_TRACE_CHK_HIST_EN
            if (!sticky_q) hist_q <= {hist_q[8:0], bus.sd};
`endif
            if (mismatch) begin
                sticky_q <= 1'b1;
                if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + 1'b1;
                if (!sticky_q) begin
                    first_exp_q <= expected;
                    first_got_q <= bus.sd;
                end
            end
            if (mismatch && HALT_ON_ERR) begin
                phase  <= HALT;
                busy_q <= 1'b0;
            end else begin
                phase  <= TRACK;
                busy_q <= 1'b1;
            end
            if (is_loop && loop_cnt_q != CNT_MAX) loop_cnt_q <= loop_cnt_q + 1'b1;
        end
    end

    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.loop_cnt   = loop_cnt_q;
    assign bus.first_exp  = first_exp_q;
    assign bus.first_got  = first_got_q;
    assign bus.busy       = busy_q;
`ifdef FSM_TRACE_CHK_HIST_EN
    assign bus.hist       = hist_q;
`endif
endmodule

// File: tb/tb_fsm_trace_checker.sv
// Scoreboarded bench: two checkers (HALT_ON_ERR 0 and 1) share one stimulus stream.
module tb_fsm_trace_checker;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fsm_trace_checker_if #(.CNT_W(8)) m0 ();
    fsm_trace_checker_if #(.CNT_W(8)) m1 ();

    fsm_trace_checker #(.CNT_W(8), .HALT_ON_ERR(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(m0.slave));
    fsm_trace_checker #(.CNT_W(8), .HALT_ON_ERR(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(m1.slave));

    typedef struct packed {
        logic err;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t push_e;
    int   cmp_cnt  = 0;
    int   fail_cnt = 0;
    int   step_no  = 0;

    // Expected err/busy of the HALT_ON_ERR=0 checker is queued per driven sample.
    task automatic step(input logic e, input logic c, input logic av, input logic [2:0] s,
                        input logic exp_err);
        m0.en = e; m0.clr = c; m0.a = av; m0.sd = s;
        m1.en = e; m1.clr = c; m1.a = av; m1.sd = s;
        push_e.err  = exp_err;
        push_e.busy = e & ~c;
        exp_q.push_back(push_e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            step_no++;
            cmp_cnt++;
            if (m0.err !== mon_e.err || m0.busy !== mon_e.busy) begin
                fail_cnt++;
                $display("FAIL step %0d err/busy: got %b/%b expected %b/%b",
                         step_no, m0.err, m0.busy, mon_e.err, mon_e.busy);
            end
        end
    end

    task automatic do_reset();
        m0.en = 0; m0.clr = 0; m0.a = 0; m0.sd = 0;
        m1.en = 0; m1.clr = 0; m1.a = 0; m1.sd = 0;
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_reset();
        m0.en = 0; m0.clr = 0; m0.a = 0; m0.sd = 0;
        m1.en = 0; m1.clr = 0; m1.a = 0; m1.sd = 0;
        #1;
        cmp_cnt++;
        if ({m0.err, m0.err_sticky, m0.err_cnt, m0.loop_cnt, m0.first_exp, m0.first_got, m0.busy} !== 23'd0) begin
            fail_cnt++;
            $display("FAIL reset_dut0: got %b expected all zero",
                     {m0.err, m0.err_sticky, m0.err_cnt, m0.loop_cnt, m0.first_exp, m0.first_got, m0.busy});
        end
        cmp_cnt++;
        if ({m1.err, m1.err_sticky, m1.err_cnt, m1.loop_cnt, m1.first_exp, m1.first_got, m1.busy} !== 23'd0) begin
            fail_cnt++;
            $display("FAIL reset_dut1: got %b expected all zero",
                     {m1.err, m1.err_sticky, m1.err_cnt, m1.loop_cnt, m1.first_exp, m1.first_got, m1.busy});
        end
        @(negedge clk) reset = 1'b1;
        step(1, 0, 0, 3'd4, 1);
        step(1, 0, 0, 3'd0, 1);
        reset = 1'b0;
        #1;
        cmp_cnt++;
        if ({m0.err, m0.err_sticky, m0.err_cnt, m0.first_exp, m0.first_got, m0.busy} !== 15'd0) begin
            fail_cnt++;
            $display("FAIL async_reset: got %b expected all zero",
                     {m0.err, m0.err_sticky, m0.err_cnt, m0.first_exp, m0.first_got, m0.busy});
        end
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_legal_walk();
        logic [2:0] seq [8];
        seq = '{3'd2, 3'd6, 3'd5, 3'd4, 3'd2, 3'd6, 3'd5, 3'd4};
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0, seq[i], 0);
        cmp_cnt++;
        if (m0.err_cnt !== 8'd0 || m0.loop_cnt !== 8'd0 || m0.err_sticky !== 1'b0) begin
            fail_cnt++;
            $display("FAIL legal_walk err_cnt/loop_cnt/sticky: got %0d/%0d/%b expected 0/0/0",
                     m0.err_cnt, m0.loop_cnt, m0.err_sticky);
        end
    endtask

    task automatic test_loop_count();
        logic [2:0] seq [8];
        seq = '{3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd6, 3'd7, 3'd5};
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 1, seq[i], 0);
        cmp_cnt++;
        if (m0.loop_cnt !== 8'd2 || m0.err_cnt !== 8'd0 || m0.err_sticky !== 1'b0) begin
            fail_cnt++;
            $display("FAIL loop_count loop_cnt/err_cnt/sticky: got %0d/%0d/%b expected 2/0/0",
                     m0.loop_cnt, m0.err_cnt, m0.err_sticky);
        end
    endtask

    task automatic test_inject_resync();
        do_reset();
        step(1, 0, 0, 3'd2, 0);
        step(1, 0, 0, 3'd6, 0);
        step(1, 0, 0, 3'd7, 1);
        cmp_cnt++;
        if (m0.first_exp !== 3'd5 || m0.first_got !== 3'd7 || m0.err_cnt !== 8'd1 || m0.err_sticky !== 1'b1) begin
            fail_cnt++;
            $display("FAIL inject first_exp/first_got/err_cnt/sticky: got %0d/%0d/%0d/%b expected 5/7/1/1",
                     m0.first_exp, m0.first_got, m0.err_cnt, m0.err_sticky);
        end
        step(1, 0, 0, 3'd5, 0);
        step(1, 0, 0, 3'd4, 0);
        cmp_cnt++;
        if (m0.err_cnt !== 8'd1 || m0.loop_cnt !== 8'd1) begin
            fail_cnt++;
            $display("FAIL inject_resync err_cnt/loop_cnt: got %0d/%0d expected 1/1", m0.err_cnt, m0.loop_cnt);
        end
    endtask

    task automatic test_first_err_halt();
        do_reset();
        step(1, 0, 0, 3'd4, 1);
        cmp_cnt++;
        if (m0.first_exp !== 3'd2 || m0.first_got !== 3'd4 || m1.first_exp !== 3'd2 ||
            m1.first_got !== 3'd4 || m1.err !== 1'b1 || m1.busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL first_err d0 exp/got %0d/%0d d1 exp/got/err/busy %0d/%0d/%b/%b expected 2/4 2/4/1/0",
                     m0.first_exp, m0.first_got, m1.first_exp, m1.first_got, m1.err, m1.busy);
        end
        step(1, 0, 0, 3'd0, 1);
        step(1, 0, 0, 3'd1, 1);
        cmp_cnt++;
        if (m0.err_cnt !== 8'd3 || m1.err_cnt !== 8'd1 || m1.err !== 1'b0 || m1.busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL halt d0 err_cnt %0d d1 err_cnt/err/busy %0d/%b/%b expected 3 1/0/0",
                     m0.err_cnt, m1.err_cnt, m1.err, m1.busy);
        end
        step(1, 1, 0, 3'd2, 0);
        cmp_cnt++;
        if (m1.err_cnt !== 8'd0 || m1.err_sticky !== 1'b0 || m1.first_exp !== 3'd0) begin
            fail_cnt++;
            $display("FAIL halt_clr d1 err_cnt/sticky/first_exp: got %0d/%b/%0d expected 0/0/0",
                     m1.err_cnt, m1.err_sticky, m1.first_exp);
        end
        step(1, 0, 1, 3'd6, 0);
        step(1, 0, 1, 3'd7, 0);
        cmp_cnt++;
        if (m1.busy !== 1'b1 || m1.err !== 1'b0 || m1.err_cnt !== 8'd0) begin
            fail_cnt++;
            $display("FAIL halt_exit d1 busy/err/err_cnt: got %b/%b/%0d expected 1/0/0", m1.busy, m1.err, m1.err_cnt);
        end
    endtask

    task automatic test_en_gap_clr();
        do_reset();
        step(1, 0, 0, 3'd2, 0);
        step(1, 0, 0, 3'd6, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 3'd2, 0);
        step(1, 0, 0, 3'd2, 0);
        cmp_cnt++;
        if (m0.err_cnt !== 8'd0) begin
            fail_cnt++;
            $display("FAIL en_gap err_cnt: got %0d expected 0", m0.err_cnt);
        end
        step(1, 0, 0, 3'd7, 1);
        step(1, 1, 0, 3'd3, 0);
        cmp_cnt++;
        if ({m0.err_sticky, m0.err_cnt, m0.loop_cnt, m0.first_exp, m0.first_got} !== 23'd0) begin
            fail_cnt++;
            $display("FAIL clr_stats: got %b expected all zero",
                     {m0.err_sticky, m0.err_cnt, m0.loop_cnt, m0.first_exp, m0.first_got});
        end
        step(1, 0, 0, 3'd5, 0);
        cmp_cnt++;
        if (m0.err_cnt !== 8'd0 || m0.err_sticky !== 1'b0) begin
            fail_cnt++;
            $display("FAIL post_clr_resync err_cnt/sticky: got %0d/%b expected 0/0", m0.err_cnt, m0.err_sticky);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        step(1, 0, 0, 3'd0, 1);
        for (int i = 0; i < 259; i++) step(1, 0, 0, (i % 2 == 0) ? 3'd1 : 3'd0, 1);
        cmp_cnt++;
        if (m0.err_cnt !== 8'd255 || m0.err_sticky !== 1'b1 || m0.first_exp !== 3'd2 || m0.first_got !== 3'd0) begin
            fail_cnt++;
            $display("FAIL saturate err_cnt/sticky/first_exp/first_got: got %0d/%b/%0d/%0d expected 255/1/2/0",
                     m0.err_cnt, m0.err_sticky, m0.first_exp, m0.first_got);
        end
    endtask

`ifdef FSM_TRACE_CHK_HIST_EN
    task automatic test_hist();
        do_reset();
        step(1, 0, 0, 3'd2, 0);
        step(1, 0, 0, 3'd6, 0);
        step(1, 0, 0, 3'd5, 0);
        step(1, 0, 0, 3'd7, 1);
        cmp_cnt++;
        if (m0.hist !== 12'o2657) begin
            fail_cnt++;
            $display("FAIL hist_capture: got %o expected 2657", m0.hist);
        end
        step(1, 0, 0, 3'd5, 0);
        step(1, 0, 0, 3'd4, 0);
        cmp_cnt++;
        if (m0.hist !== 12'o2657) begin
            fail_cnt++;
            $display("FAIL hist_frozen: got %o expected 2657", m0.hist);
        end
        step(1, 1, 0, 3'd2, 0);
        cmp_cnt++;
        if (m0.hist !== 12'o0) begin
            fail_cnt++;
            $display("FAIL hist_clr: got %o expected 0", m0.hist);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_legal_walk();
        test_loop_count();
        test_inject_resync();
        test_first_err_halt();
        test_en_gap_clr();
        test_saturate();
`ifdef FSM_TRACE_CHK_HIST_EN
        test_hist();
`endif
        cmp_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/fsm_trace_checker.md
Name: fsm_trace_checker

Overview:
- Downstream monitor for the 3-bit state FSM (codes 2,4,5,6,7 driven by input a).
- Samples the FSM state output sd together with the same a that drives the FSM.
- Predicts each next state from the legal transition table and flags mismatches.
- Reports sticky error status, first-error capture and loop statistics to the testbench/top level.

Parameters:
- CNT_W, 8: width of err_cnt and loop_cnt; both counters saturate at 2^CNT_W-1.
- HALT_ON_ERR, 0: when 1, checking stops after the first error until clr.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- en, input, 1: sample enable; high means the FSM advanced this cycle.
- clr, input, 1: synchronous clear of statistics, returns checker to RESYNC.
- a, input, 1: same a applied to the FSM at this edge.
- sd, input, 3: FSM current-state code.
- err, output, 1: one-cycle pulse, the cycle after a mismatching sample.
- err_sticky, output, 1: set on any error, cleared only by reset or clr.
- err_cnt, output, CNT_W: saturating error count.
- loop_cnt, output, CNT_W: saturating count of observed legal 7->5 transitions.
- first_exp, output, 3: expected code at the first error.
- first_got, output, 3: observed code at the first error.
- busy, output, 1: high in TRACK.

Behaviour:
- Reset values:
  - All outputs 0.
  - prev_sd=0, prev_a=0.
  - Phase = INIT.
- Next-state function nxt(s,a):
  - 2->6 and 5->4 and 7->5.
  - 4->(a?6:2).
  - 6->(a?7:5).
  - Illegal codes 0,1,3 -> same code (hold).
- Phases, evaluated only on edges with en=1:
  - INIT: expected = 2. Mismatch -> error. Always go to TRACK.
  - TRACK: expected = nxt(prev_sd,prev_a). Mismatch -> error.
  - RESYNC: no check. Go to TRACK.
  - HALT: no check, no counter updates. Exit only via clr or reset.
- On every en=1 edge in INIT/TRACK/RESYNC: prev_sd<=sd, prev_a<=a. Observed sd is adopted even after an error, so checking resynchronises.
- Illegal sd (0,1,3) is always an error, because expected is never illegal from a legal prev.
- en=0: no sampling, no checks, registers hold, err=0. If the phase was TRACK, it becomes RESYNC, because continuity is lost.
- Error actions (same edge):
  - err<=1 for exactly one cycle.
  - err_sticky<=1.
  - err_cnt+1, saturating.
  - If err_sticky was 0: first_exp<=expected, first_got<=sd.
  - If HALT_ON_ERR=1: phase<=HALT, busy<=0.
- loop_cnt increments on a TRACK check with prev_sd=7, sd=5 and no error; it saturates.
- Latency: sd/a sampled at edge k; err, counters and busy updated at edge k, visible in cycle k..k+1.
- clr=1 at an edge:
  - Clears err, err_sticky, err_cnt, loop_cnt, first_exp, first_got.
  - Phase<=RESYNC; RESYNC still captures sd/a on that edge when en=1.
  - clr wins over a simultaneous mismatch: no error is recorded.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.
- Saturated counter plus error: err and err_sticky still assert; the count holds.

Optional Feature:
- Macro: FSM_TRACE_CHK_HIST_EN.
- Defined:
  - Adds output hist, 12 bits.
  - hist is a shift register of the last 4 sampled sd codes, newest in [2:0]. It shifts on every en=1 edge in INIT/TRACK/RESYNC.
  - Freezes when err_sticky first sets and stays frozen until clr.
  - Reset/clr value 0.
- Not defined: no hist port and no history logic; all other behaviour is identical.

Test Plan:
- Reset then en=1, a=0 for 8 cycles, sd=2,6,5,4,2,6,5,4 -> err never pulses; err_cnt=0; loop_cnt=0; busy=1 from the 2nd edge.
- a=1 held, sd=2,6,7,5,4,6,7,5 -> loop_cnt=2; err_cnt=0; err_sticky=0.
- Inject sd=7 after prev 6 with prev_a=0 -> err pulses 1 cycle; err_cnt=1; first_exp=5, first_got=7. Next legal sample 5 gives no error (resync).
- First sample after reset sd=4 -> error with first_exp=2, first_got=4. HALT_ON_ERR=1: following mismatches do not change err_cnt, busy=0, until clr.
- en low 3 cycles while sd jumps 6->2 -> no error on the first en=1 sample (RESYNC). clr pulsed together with an injected illegal sd=3 -> all stats 0, err not pulsed.
- Drive err_cnt past 255 (CNT_W=8) with alternating illegal codes -> err_cnt holds 255 and err still pulses. With FSM_TRACE_CHK_HIST_EN, hist freezes at the first error value, e.g. 12'o2657 for sd 2,6,5,7.
